// File: rtl/rv_run_supervisor.sv
// Run supervisor for the RV32I MCU: sequences core reset, decodes host-communication
// stores, and ends each run as pass, fail or timeout with cycle/retire counts.
module rv_run_supervisor #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       CNT_W          = 32,
  parameter int unsigned       RESET_CYCLES   = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 3000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_0FF0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              instr_retire,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic              console_valid,
  output logic [7:0]        console_byte,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic [DATA_W-2:0]  fail_code_q, fail_code_d;
  logic [7:0]         cons_byte_q, cons_byte_d;
  logic               cons_valid_q, cons_valid_d;
  logic               core_rst_q, core_rst_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;

  logic tohost_wr_c, wr_pass_c, wr_fail_c, wr_cons_c;

  // Decode of a store to the host-communication address
  always_comb begin
    tohost_wr_c = bus_we && (bus_addr == TOHOST_ADDR);
    wr_pass_c   = tohost_wr_c && (bus_wdata == DATA_W'(1));
    wr_fail_c   = tohost_wr_c && bus_wdata[0] && !wr_pass_c;
    wr_cons_c   = tohost_wr_c && !bus_wdata[0];
  end

  // Next-state and next-output logic; status flags follow the next state
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cycle_d      = cycle_q;
    retire_d     = retire_q;
    fail_code_d  = fail_code_q;
    cons_byte_d  = cons_byte_q;
    cons_valid_d = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        // The terminating cycle itself and its retire pulse are counted
        cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
        if (instr_retire && (retire_q != CNT_MAX)) begin
          retire_d = retire_q + CNT_W'(1);
        end
        if (wr_pass_c) begin
          state_d = ST_PASS;
        end else if (wr_fail_c) begin
          state_d     = ST_FAIL;
          fail_code_d = bus_wdata[DATA_W-1:1];
        end else begin
          if (wr_cons_c) begin
            cons_valid_d = 1'b1;
            cons_byte_d  = bus_wdata[8:1];
          end
          // A terminating write on the last allowed cycle takes priority over timeout
          if (cycle_q == TMO_LAST) begin
            state_d = ST_TIMEOUT;
          end
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) begin
          state_d     = ST_HOLD;
          hold_d      = '0;
          cycle_d     = '0;
          retire_d    = '0;
          fail_code_d = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase

    core_rst_d = (state_d == ST_HOLD);
    running_d  = (state_d == ST_RUN);
    done_d     = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d     = (state_d == ST_PASS);
    timeout_d  = (state_d == ST_TIMEOUT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      cycle_q      <= '0;
      retire_q     <= '0;
      fail_code_q  <= '0;
      cons_byte_q  <= '0;
      cons_valid_q <= 1'b0;
      core_rst_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
      fail_code_q  <= fail_code_d;
      cons_byte_q  <= cons_byte_d;
      cons_valid_q <= cons_valid_d;
      core_rst_q   <= core_rst_d;
      running_q    <= running_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_rst      = core_rst_q;
  assign running       = running_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign fail_code     = fail_code_q;
  assign console_valid = cons_valid_q;
  assign console_byte  = cons_byte_q;
  assign cycle_count   = cycle_q;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_rv_run_supervisor.sv
// Scoreboard bench for rv_run_supervisor: a run-level reference model queues
// expected console bytes and run results; a monitor pops and compares them.
module tb_rv_run_supervisor;

  localparam int unsigned RC     = 4;
  localparam int unsigned TMO    = 200;
  localparam logic [31:0] TOHOST = 32'h0000_0FF0;

  localparam int K_PASS = 1;
  localparam int K_FAIL = 2;
  localparam int K_TMO  = 3;

  typedef struct {
    int          kind;
    logic [30:0] code;
    int          cycles;
    int          retires;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        instr_retire;
  logic        core_rst, running, done, pass, timeout, console_valid;
  logic [30:0] fail_code;
  logic [7:0]  console_byte;
  logic [31:0] cycle_count, retire_count;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] cons_q[$];
  res_t       res_q[$];
  res_t       last_res;
  logic       done_prev = 1'b0;

  rv_run_supervisor #(
    .DATA_W(32), .ADDR_W(32), .CNT_W(32),
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TMO), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .instr_retire(instr_retire),
    .core_rst(core_rst), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .fail_code(fail_code), .console_valid(console_valid),
    .console_byte(console_byte), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; instr_retire = 1'b0; start = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_fail_code", 64'(fail_code), 64'd0);
    check("rst_console_valid", 64'(console_valid), 64'd0);
    check("rst_console_byte", 64'(console_byte), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_retire_count", 64'(retire_count), 64'd0);
  endtask

  // Called at the negedge before the first HOLD edge; drives traffic that must be ignored
  task automatic hold_phase();
    for (int i = 0; i < int'(RC); i++) begin
      check("hold_core_rst", 64'(core_rst), 64'd1);
      check("hold_running", 64'(running), 64'd0);
      check("hold_cycle_count", 64'(cycle_count), 64'd0);
      bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = $urandom;
      instr_retire = 1'b1; start = 1'b1;
      @(negedge clk);
    end
    idle();
    check("run_entry_core_rst", 64'(core_rst), 64'd0);
    check("run_entry_running", 64'(running), 64'd1);
    check("run_entry_done", 64'(done), 64'd0);
    check("run_entry_cycle_count", 64'(cycle_count), 64'd0);
    check("run_entry_retire_count", 64'(retire_count), 64'd0);
  endtask

  // Drives one run cycle by cycle; the model counts cycles and retires and decodes tohost stores.
  // term_kind 0 = no terminating write; directed runs retire on odd cycles up to 73 (37 pulses).
  task automatic drive_run(input int term_at, input int term_kind, input logic [31:0] tdata,
                           input bit directed, input int cons_at, input logic [31:0] cons_data);
    int   k = 0;
    int   ret = 0;
    bit   fin = 1'b0;
    res_t r;
    logic [31:0] d;
    while (!fin) begin
      k++;
      idle();
      instr_retire = directed ? ((k % 2 == 1) && (k <= 73)) : 1'($urandom_range(0, 1));
      if (term_kind != 0 && k == term_at) begin
        bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = tdata;
      end else if (directed) begin
        if (k == cons_at) begin
          bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = cons_data;
        end
      end else begin
        case ($urandom_range(0, 7))
          0: begin
            d = $urandom; d[0] = 1'b0;
            bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = d;
          end
          1: begin bus_we = 1'b1; bus_addr = TOHOST + 32'd4; bus_wdata = 32'd1; end
          2: begin bus_we = 1'b0; bus_addr = TOHOST; bus_wdata = 32'd3; end
          3: start = 1'b1;
          default: ;
        endcase
      end
      ret += int'(instr_retire);
      d = bus_wdata;
      if (bus_we && bus_addr == TOHOST) begin
        if (d == 32'd1) begin
          fin = 1'b1; r.kind = K_PASS; r.code = '0;
        end else if (d[0]) begin
          fin = 1'b1; r.kind = K_FAIL; r.code = d[31:1];
        end else begin
          cons_q.push_back(d[8:1]);
        end
      end
      if (!fin && k == int'(TMO)) begin
        fin = 1'b1; r.kind = K_TMO; r.code = '0;
      end
      if (fin) begin
        r.cycles = k; r.retires = ret;
        res_q.push_back(r);
        last_res = r;
      end
      @(negedge clk);
    end
    idle();
    check("term_latency_done", 64'(done), 64'd1);
    check("term_latency_running", 64'(running), 64'd0);
  endtask

  // Terminal states must ignore all traffic and keep counters frozen
  task automatic freeze(input int n);
    for (int i = 0; i < n; i++) begin
      bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = $urandom_range(0, 7);
      instr_retire = 1'($urandom_range(0, 1)); start = 1'b0;
      @(negedge clk);
    end
    idle();
    check("freeze_cycle_count", 64'(cycle_count), 64'(last_res.cycles));
    check("freeze_retire_count", 64'(retire_count), 64'(last_res.retires));
    check("freeze_done", 64'(done), 64'd1);
    check("freeze_pass", 64'(pass), 64'(last_res.kind == K_PASS));
    check("freeze_timeout", 64'(timeout), 64'(last_res.kind == K_TMO));
    check("freeze_fail_code", 64'(fail_code), 64'(last_res.code));
  endtask

  task automatic restart();
    idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_core_rst", 64'(core_rst), 64'd1);
    check("restart_done", 64'(done), 64'd0);
    check("restart_pass", 64'(pass), 64'd0);
    check("restart_timeout", 64'(timeout), 64'd0);
    check("restart_fail_code", 64'(fail_code), 64'd0);
    check("restart_cycle_count", 64'(cycle_count), 64'd0);
    check("restart_retire_count", 64'(retire_count), 64'd0);
    hold_phase();
  endtask

  // Run n cycles with only console traffic and start noise, then pull reset mid-run
  task automatic abort_run(input int n);
    logic [31:0] d;
    for (int k = 1; k <= n; k++) begin
      idle();
      instr_retire = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom; d[0] = 1'b0;
        bus_we = 1'b1; bus_addr = TOHOST; bus_wdata = d;
        cons_q.push_back(d[8:1]);
      end
      @(negedge clk);
    end
    idle();
    check("abort_running_before", 64'(running), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    hold_phase();
  endtask

  // Monitor: pops expectations whenever the DUT presents a console pulse or a new result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (console_valid) begin
        if (cons_q.size() == 0) begin
          check("console_unexpected", 64'(console_byte), 64'hFFFF);
        end else begin
          check("console_byte", 64'(console_byte), 64'(cons_q.pop_front()));
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          check("result_unexpected", 64'(done), 64'd0);
        end else begin
          res_t e;
          e = res_q.pop_front();
          check("res_pass", 64'(pass), 64'(e.kind == K_PASS));
          check("res_timeout", 64'(timeout), 64'(e.kind == K_TMO));
          check("res_fail_code", 64'(fail_code), 64'(e.code));
          check("res_cycle_count", 64'(cycle_count), 64'(e.cycles));
          check("res_retire_count", 64'(retire_count), 64'(e.retires));
          check("res_running", 64'(running), 64'd0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected completion before 1000000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int ta;
    int kd;
    logic [31:0] fd;
    reset = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    hold_phase();

    // Directed pass: write 1 on RUN cycle 101 with 37 retires
    drive_run(101, K_PASS, 32'h1, 1'b1, 0, 32'h0);
    freeze(50);

    // Console byte 0x41 then fail with code 5
    restart();
    drive_run(9, K_FAIL, 32'h0000_000B, 1'b1, 5, 32'h0000_0082);
    freeze(10);

    // Pure timeout, then a pass write on the final allowed cycle
    restart();
    drive_run(0, 0, 32'h0, 1'b0, 0, 32'h0);
    freeze(10);
    restart();
    drive_run(int'(TMO), K_PASS, 32'h1, 1'b0, 0, 32'h0);
    freeze(5);

    // Fail write on the final allowed cycle
    restart();
    drive_run(int'(TMO), K_FAIL, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    freeze(5);

    // Abort mid-run via reset
    restart();
    abort_run(30);

    // Randomized runs
    for (int n = 0; n < 8; n++) begin
      ta = $urandom_range(1, int'(TMO) + 20);
      kd = $urandom_range(0, 2);
      fd = ($urandom | 32'h1);
      if (fd == 32'h1) fd = 32'h3;
      drive_run(ta, kd, (kd == K_PASS) ? 32'h1 : fd, 1'b0, 0, 32'h0);
      freeze($urandom_range(1, 8));
      restart();
    end

    repeat (5) @(negedge clk);
    check("console_queue_drained", 64'(cons_q.size()), 64'd0);
    check("result_queue_drained", 64'(res_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
